// File: rtl/traffic_phase_ctrl.sv
// Multi-phase traffic signal controller: tick prescaler, actuated green timing,
// round-robin phase selection and a maintenance flashing-yellow mode.
module traffic_phase_ctrl #(
    parameter int NUM_PHASES = 4,
    parameter int TICK_DIV   = 50000000,
    parameter int CNT_W      = 8,
    parameter int GREEN_MIN  = 5,
    parameter int GREEN_MAX  = 20,
    parameter int YELLOW_T   = 3,
    parameter int ALLRED_T   = 1,
    parameter int PH_W       = (NUM_PHASES > 2) ? $clog2(NUM_PHASES) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_PHASES-1:0] req,
    input  logic                  flash_en,
    output logic [NUM_PHASES-1:0] red,
    output logic [NUM_PHASES-1:0] yellow,
    output logic [NUM_PHASES-1:0] green,
    output logic [PH_W-1:0]       phase,
    output logic [1:0]            state,
    output logic                  tick
);

    typedef enum logic [1:0] {
        S_GREEN  = 2'b00,
        S_YELLOW = 2'b01,
        S_ALLRED = 2'b10,
        S_FLASH  = 2'b11
    } state_t;

    localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [DIV_W-1:0]      presc;
    state_t                st;
    logic [PH_W-1:0]       ph;
    logic [CNT_W-1:0]      timer;
    logic [NUM_PHASES-1:0] pending;
    logic                  flash_bit;

    logic [NUM_PHASES-1:0] self_mask;
    logic [NUM_PHASES-1:0] next_mask;
    logic [PH_W-1:0]       next_ph;
    logic                  found;
    logic                  demand;

    assign tick  = (presc == DIV_W'(TICK_DIV - 1));
    assign phase = ph;
    assign state = st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    presc <= '0;
        else if (tick) presc <= '0;
        else           presc <= presc + 1'b1;
    end

    // Round-robin search starts after the current phase and visits it last.
    always_comb begin
        found   = 1'b0;
        next_ph = '0;
        for (int i = 1; i <= NUM_PHASES; i++) begin
            if (!found && pending[(int'(ph) + i) % NUM_PHASES]) begin
                next_ph = PH_W'((int'(ph) + i) % NUM_PHASES);
                found   = 1'b1;
            end
        end
        for (int q = 0; q < NUM_PHASES; q++) begin
            self_mask[q] = (ph == PH_W'(q));
            next_mask[q] = (next_ph == PH_W'(q));
        end
        demand = (|(pending & ~self_mask)) || (ph != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= S_ALLRED;
            ph        <= '0;
            timer     <= '0;
            pending   <= '0;
            flash_bit <= 1'b0;
        end else begin
            pending <= pending | req;
            if (tick) begin
                // Saturating keeps >= comparisons valid during an indefinite rest.
                if (timer != '1) timer <= timer + 1'b1;
                unique case (st)
                    S_GREEN: begin
                        if (flash_en ||
                            (demand && (timer >= CNT_W'(GREEN_MAX - 1) ||
                                        (timer >= CNT_W'(GREEN_MIN - 1) && !req[ph])))) begin
                            st    <= S_YELLOW;
                            timer <= '0;
                        end
                    end
                    S_YELLOW: begin
                        if (timer >= CNT_W'(YELLOW_T - 1)) begin
                            st    <= S_ALLRED;
                            timer <= '0;
                        end
                    end
                    S_ALLRED: begin
                        if (timer >= CNT_W'(ALLRED_T - 1)) begin
                            timer <= '0;
                            if (flash_en) begin
                                st        <= S_FLASH;
                                flash_bit <= 1'b1;
                            end else begin
                                st      <= S_GREEN;
                                ph      <= next_ph;
                                pending <= (pending | req) & ~next_mask;
                            end
                        end
                    end
                    S_FLASH: begin
                        if (!flash_en) begin
                            st    <= S_ALLRED;
                            ph    <= '0;
                            timer <= '0;
                        end else begin
                            flash_bit <= ~flash_bit;
                        end
                    end
                endcase
            end
        end
    end

    always_comb begin
        red    = '0;
        yellow = '0;
        green  = '0;
        unique case (st)
            S_GREEN: begin
                green = self_mask;
                red   = ~self_mask;
            end
            S_YELLOW: begin
                yellow = self_mask;
                red    = ~self_mask;
            end
            S_ALLRED: red    = '1;
            S_FLASH:  yellow = {NUM_PHASES{flash_bit}};
        endcase
    end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: tick-level behavioural model compared every cycle,
// plus directed scenarios with hand-computed lamp expectations.
module tb_traffic_phase_ctrl;

    localparam int N    = 4;
    localparam int TD   = 4;
    localparam int GMIN = 5;
    localparam int GMAX = 20;
    localparam int YT   = 3;
    localparam int ART  = 1;
    localparam int M_G = 0, M_Y = 1, M_A = 2, M_F = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [N-1:0] req = '0;
    logic         flash_en = 1'b0;
    logic [N-1:0] red, yellow, green;
    logic [1:0]   phase;
    logic [1:0]   state;
    logic         tick;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    traffic_phase_ctrl #(.NUM_PHASES(N), .TICK_DIV(TD)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .flash_en(flash_en),
        .red(red), .yellow(yellow), .green(green),
        .phase(phase), .state(state), .tick(tick)
    );

    always #5 clk = ~clk;

    // Model: elapsed ticks in the current interval, pending set, prescaler as integers.
    int     m_st = M_A, m_ph = 0, m_el = 0, m_presc = 0;
    bit [N-1:0] m_pend = '0;
    bit     m_fl = 0;

    always @(posedge clk or negedge rst_n) begin : model
        bit t, dem;
        int done, nst, nph, q;
        if (!rst_n) begin
            m_st = M_A; m_ph = 0; m_el = 0; m_pend = '0; m_presc = 0; m_fl = 0;
        end else begin
            t       = (m_presc == TD - 1);
            m_presc = (m_presc + 1) % TD;
            nst = m_st;
            nph = m_ph;
            if (t) begin
                done = m_el + 1;
                case (m_st)
                    M_G: begin
                        dem = (m_ph != 0);
                        for (int k = 0; k < N; k++) if (k != m_ph && m_pend[k]) dem = 1;
                        if (flash_en || (dem && (done >= GMAX || (done >= GMIN && !req[m_ph]))))
                            nst = M_Y;
                    end
                    M_Y: if (done >= YT) nst = M_A;
                    M_A: if (done >= ART) begin
                        if (flash_en) begin
                            nst = M_F; m_fl = 1;
                        end else begin
                            nst = M_G; nph = 0;
                            for (int k = N; k >= 1; k--) begin
                                q = (m_ph + k) % N;
                                if (m_pend[q]) nph = q;
                            end
                        end
                    end
                    M_F: if (!flash_en) begin nst = M_A; nph = 0; end
                         else m_fl = !m_fl;
                    default: ;
                endcase
            end
            m_pend = m_pend | req;
            if (nst == M_G && m_st != M_G) m_pend[nph] = 0;
            if (nst != m_st || nph != m_ph) m_el = 0;
            else if (t) m_el = m_el + 1;
            m_st = nst;
            m_ph = nph;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin : compare
        logic [N-1:0] er, ey, eg;
        logic [16:0]  ev, av;
        int nonred;
        bit ok;
        if (chk_en) begin
            er = '0; ey = '0; eg = '0;
            if (m_st == M_F)      ey = m_fl ? '1 : '0;
            else if (m_st == M_A) er = '1;
            else begin
                er = ~(N'(1) << m_ph);
                if (m_st == M_G) eg = N'(1) << m_ph;
                else             ey = N'(1) << m_ph;
            end
            ev = {2'(m_st), 2'(m_ph), (m_presc == TD - 1), er, ey, eg};
            av = {state, phase, tick, red, yellow, green};
            check("model_outputs", 32'(av), 32'(ev));
            if (m_st != M_F) begin
                ok = 1; nonred = 0;
                for (int k = 0; k < N; k++) begin
                    if (32'(red[k]) + 32'(yellow[k]) + 32'(green[k]) != 1) ok = 0;
                    if (!red[k]) nonred++;
                end
                if (nonred > 1) ok = 0;
                check("lamp_invariant", 32'(ok), 32'd1);
            end
        end
    end

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            int k;
            k = 0;
            do begin @(negedge clk); k++; end while (!tick && k < 16);
            if (!tick) begin
                n_cmp++; n_bad++;
                $display("FAIL tick_timeout: no tick in %0d cycles, required one", k);
            end
        end
    endtask

    task automatic wait_green(input logic [N-1:0] pat, input int bound);
        int k;
        k = 0;
        while (green !== pat && k < bound) begin @(negedge clk); k++; end
        check("wait_green", 32'(green), 32'(pat));
    endtask

    task automatic count_green(input logic [N-1:0] pat, output int cnt);
        cnt = 1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (green === pat) cnt++;
            else break;
        end
    endtask

    task automatic pulse_req(input logic [N-1:0] r);
        @(negedge clk); req = r;
        @(negedge clk); req = '0;
    endtask

    initial begin
        int cnt, k;
        #2 rst_n = 1'b0;
        chk_en = 1;
        repeat (2) @(negedge clk);
        check("rst_red", 32'(red), 32'hF);
        check("rst_state", 32'(state), 32'd2);
        check("rst_tick", 32'(tick), 32'd0);
        rst_n = 1'b1;

        // Reset release: one all-red tick then GREEN(0).
        wait_ticks(1);
        @(negedge clk);
        check("green0_after_reset", 32'(green), 32'h1);
        check("state_green", 32'(state), 32'd0);

        // Request on phase 2 early in GREEN(0); gap-out on the 5th tick.
        wait_ticks(2);
        pulse_req(4'b0100);
        wait_ticks(3);
        @(negedge clk);
        check("yellow0_tick5", 32'(yellow), 32'h1);
        wait_ticks(4);
        @(negedge clk);
        check("green2", 32'(green), 32'h4);
        check("phase2", 32'(phase), 32'd2);
        wait_ticks(5);
        @(negedge clk);
        check("yellow2_gapout", 32'(yellow), 32'h4);
        wait_ticks(4);
        @(negedge clk);
        check("back_green0", 32'(green), 32'h1);

        // Held requests on 0 and 1: each serves GREEN_MAX ticks (80 clk).
        req = 4'b0011;
        count_green(4'b0001, cnt);
        check("max_green0_cycles", 32'(cnt), 32'd80);
        wait_green(4'b0010, 40);
        count_green(4'b0010, cnt);
        check("max_green1_cycles", 32'(cnt), 32'd80);
        wait_green(4'b0001, 40);
        check("phase0_again", 32'(phase), 32'd0);
        req = '0;

        // Rest in GREEN(0); tick period stays 4 clk.
        repeat (200) @(negedge clk);
        check("rest_green0", 32'(green), 32'h1);
        wait_ticks(1);
        k = 0;
        do begin @(negedge clk); k++; end while (!tick && k < 10);
        check("tick_period", 32'(k), 32'd4);

        // Pending 1 and 3 while 3 is served: 3 -> 1 -> 3 -> 0.
        pulse_req(4'b1000);
        wait_green(4'b1000, 100);
        pulse_req(4'b1010);
        wait_green(4'b0010, 100);
        check("rr_phase1", 32'(phase), 32'd1);
        wait_green(4'b1000, 100);
        wait_green(4'b0001, 100);

        // Flash mode entered from mid-GREEN(1).
        repeat (40) @(negedge clk);
        pulse_req(4'b0010);
        wait_green(4'b0010, 100);
        wait_ticks(2);
        @(negedge clk); flash_en = 1'b1;
        wait_ticks(1);
        @(negedge clk);
        check("flash_yellow1", 32'(yellow), 32'h2);
        wait_ticks(4);
        @(negedge clk);
        check("flash_state", 32'(state), 32'd3);
        check("flash_on", 32'(yellow), 32'hF);
        wait_ticks(1);
        @(negedge clk);
        check("flash_off", 32'({red, yellow, green}), 32'h0);
        wait_ticks(1);
        @(negedge clk);
        check("flash_on2", 32'(yellow), 32'hF);
        flash_en = 1'b0;
        wait_ticks(1);
        @(negedge clk);
        check("flash_exit_allred", 32'(red), 32'hF);
        check("flash_exit_phase", 32'(phase), 32'd0);
        wait_ticks(1);
        @(negedge clk);
        check("flash_exit_green0", 32'(green), 32'h1);

        // Asynchronous reset while in YELLOW.
        repeat (40) @(negedge clk);
        pulse_req(4'b0100);
        k = 0;
        while (state !== 2'b01 && k < 100) begin @(negedge clk); k++; end
        check("reach_yellow", 32'(state), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_red", 32'(red), 32'hF);
        check("async_rst_yg", 32'({yellow, green}), 32'h0);
        check("async_rst_state", 32'(state), 32'd2);
        check("async_rst_phase", 32'(phase), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        wait_ticks(1);
        @(negedge clk);
        check("post_rst_green0", 32'(green), 32'h1);

        repeat (4) @(negedge clk);
        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
